// File: rtl/fm_modulator.sv
// -----------------------------------------------------------------------------
// fm_modulator
//   Streaming FM baseband modulator. Each accepted 16-bit signed audio sample
//   sets the per-sample phase increment (carrier + scaled deviation); the
//   sample is tagged with the current accumulator phase, which is mapped to a
//   complex unit phasor (I = cos, Q = sin, Q1.15 scaled by 32767) through a
//   quarter-wave sine table.
//
//   Pipeline: S1 phase accumulate -> S2 quarter-wave table read ->
//             S3 quadrant sign/mirror fold into the output register.
//   The whole pipeline freezes while the output word is held off by the sink.
//
// Ports
//   s00_axis_aclk      : sole clock
//   s00_axis_aresetn   : asynchronous active-low reset
//   s00_axis_t*        : input stream, tdata[15:0] = signed audio sample
//                        (upper tdata bits and tstrb are ignored)
//   m00_axis_t*        : output stream, tdata[15:0] = I, tdata[31:16] = Q
//
// Build option
//   FM_MOD_DITHER_EN   : when defined, a 16-bit Fibonacci LFSR
//                        (x^16+x^14+x^13+x^11+1, seed 16'hACE1) dithers the
//                        phase bits below the table address.
// -----------------------------------------------------------------------------
module fm_modulator #(
  parameter int     C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int     C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int     PHASE_WIDTH            = 24,
  parameter longint CENTER_INC             = 0,
  parameter int     DEV_SHIFT              = 0
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  // input stream
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  // output stream
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb
);

  localparam int                     LP_DW     = PHASE_WIDTH - 10;
  localparam logic [PHASE_WIDTH-1:0] LP_CENTER = PHASE_WIDTH'(CENTER_INC);
  localparam real                    LP_PI     = 3.14159265358979323846;

  typedef enum logic [1:0] {
    QUAD_I   = 2'd0,
    QUAD_II  = 2'd1,
    QUAD_III = 2'd2,
    QUAD_IV  = 2'd3
  } quadrant_e;

  // ---------------------------------------------------------------------------
  // Quarter-wave table T[k] = round(32767 * sin(pi*k/512)), k = 0..256.
  // Evaluated at elaboration only; the table is constant logic.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] quarter_sine(input int k);
    real v;
    v = 32767.0 * $sin(LP_PI * k / 512.0);
    return 16'($rtoi(v + 0.5));
  endfunction

  // NOTE: the table is pure combinational constants rather than a storage
  // array, so there is nothing to reset or initialise at run time.
  logic [15:0] w_table [0:256];
  for (genvar k = 0; k <= 256; k++) begin : g_table
    localparam logic [15:0] LP_T = quarter_sine(k);
    assign w_table[k] = LP_T;
  end

  // ---------------------------------------------------------------------------
  // Handshake: the only back-pressure point is the output register.
  // ---------------------------------------------------------------------------
  logic w_stall;
  logic r_s3_valid;

  assign w_stall         = r_s3_valid && !m00_axis_tready;
  assign s00_axis_tready = !w_stall;

  // ---------------------------------------------------------------------------
  // S1: phase accumulate
  // ---------------------------------------------------------------------------
  logic signed [PHASE_WIDTH-1:0] w_sample;
  logic        [PHASE_WIDTH-1:0] w_inc;
  logic        [PHASE_WIDTH-1:0] w_phase_tap;
  logic        [9:0]             w_addr;
  logic        [PHASE_WIDTH-1:0] r_phi;
  logic                          r_s1_valid;
  logic                          r_s1_last;
  logic        [9:0]             r_s1_addr;

  assign w_sample = PHASE_WIDTH'(signed'(s00_axis_tdata[15:0]));
  assign w_inc    = LP_CENTER + PHASE_WIDTH'(w_sample <<< DEV_SHIFT);

`ifdef FM_MOD_DITHER_EN
  localparam logic [PHASE_WIDTH-1:0] LP_LOW_MASK = {{10{1'b0}}, {LP_DW{1'b1}}};

  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Dither is added only below the address LSB; a carry may still bump the
  // address, which is the point of dithering.
  assign w_phase_tap = r_phi + (PHASE_WIDTH'(r_lfsr) & LP_LOW_MASK);

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_lfsr <= 16'hACE1;
    end else if (s00_axis_tvalid && !w_stall) begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end
`else
  assign w_phase_tap = r_phi;
`endif

  assign w_addr = w_phase_tap[PHASE_WIDTH-1 -: 10];

  // NOTE: every clocked register uses non-blocking assignment so all stages
  // sample their inputs from the same edge and the pipeline shifts as a unit.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_phi      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_addr  <= '0;
    end else if (!w_stall) begin
      // A bubble at the input moves down the pipe as a bubble.
      r_s1_valid <= s00_axis_tvalid;
      r_s1_last  <= s00_axis_tlast;
      r_s1_addr  <= w_addr;
      if (s00_axis_tvalid) begin
        r_phi <= r_phi + w_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: quarter-wave table read. Both T[a] and T[256-a] are fetched so S3
  // can build sin and cos for any quadrant from the in-quadrant offset a.
  // ---------------------------------------------------------------------------
  logic      [8:0]  w_idx_a;
  logic      [8:0]  w_idx_b;
  logic             r_s2_valid;
  logic             r_s2_last;
  quadrant_e        r_s2_quad;
  logic      [15:0] r_s2_ta;
  logic      [15:0] r_s2_tb;

  assign w_idx_a = {1'b0, r_s1_addr[7:0]};
  assign w_idx_b = 9'd256 - w_idx_a;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_quad  <= QUAD_I;
      r_s2_ta    <= '0;
      r_s2_tb    <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_quad  <= quadrant_e'(r_s1_addr[9:8]);
      r_s2_ta    <= w_table[w_idx_a];
      r_s2_tb    <= w_table[w_idx_b];
    end
  end

  // ---------------------------------------------------------------------------
  // S3: quadrant fold. Table entries never exceed 32767, so negation can
  // never produce -32768.
  // ---------------------------------------------------------------------------
  logic [15:0] w_fold_i;
  logic [15:0] w_fold_q;
  logic [15:0] r_s3_i;
  logic [15:0] r_s3_q;
  logic        r_s3_last;

  // NOTE: both outputs get a default before the case so no path can leave
  // them unassigned and infer a latch.
  always_comb begin
    w_fold_i = r_s2_tb;
    w_fold_q = r_s2_ta;
    case (r_s2_quad)
      QUAD_I: begin
        w_fold_i = r_s2_tb;
        w_fold_q = r_s2_ta;
      end
      QUAD_II: begin
        w_fold_i = -r_s2_ta;
        w_fold_q = r_s2_tb;
      end
      QUAD_III: begin
        w_fold_i = -r_s2_tb;
        w_fold_q = -r_s2_ta;
      end
      QUAD_IV: begin
        w_fold_i = r_s2_ta;
        w_fold_q = -r_s2_tb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      r_s3_i     <= '0;
      r_s3_q     <= '0;
    end else if (!w_stall) begin
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
      r_s3_i     <= w_fold_i;
      r_s3_q     <= w_fold_q;
    end
  end

  assign m00_axis_tvalid = r_s3_valid;
  assign m00_axis_tlast  = r_s3_last;
  assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'({r_s3_q, r_s3_i});
  assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){r_s3_valid}};

  // Inputs (and low phase bits) that intentionally do not feed any logic.
  logic w_unused_ok;
  assign w_unused_ok = ^{s00_axis_tstrb, s00_axis_tdata, w_phase_tap[LP_DW-1:0]};

endmodule

// File: tb/tb_fm_modulator.sv
// -----------------------------------------------------------------------------
// tb_fm_modulator
//   Directed bench for fm_modulator (PHASE_WIDTH=24, DEV_SHIFT=0).
//   dut  : CENTER_INC = 0
//   dut1 : CENTER_INC = 2^23 (shares all inputs with dut)
// -----------------------------------------------------------------------------
module tb_fm_modulator;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        m_tready;

  logic        s0_tready, m0_tvalid, m0_tlast;
  logic [31:0] m0_tdata;
  logic [3:0]  m0_tstrb;
  logic        s1_tready, m1_tvalid, m1_tlast;
  logic [31:0] m1_tdata;
  logic [3:0]  m1_tstrb;

  fm_modulator #(.PHASE_WIDTH(24), .CENTER_INC(0), .DEV_SHIFT(0)) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s0_tready),
    .m00_axis_tready(m_tready), .m00_axis_tvalid(m0_tvalid),
    .m00_axis_tlast(m0_tlast), .m00_axis_tdata(m0_tdata),
    .m00_axis_tstrb(m0_tstrb)
  );

  fm_modulator #(.PHASE_WIDTH(24), .CENTER_INC(2**23), .DEV_SHIFT(0)) dut1 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s1_tready),
    .m00_axis_tready(m_tready), .m00_axis_tvalid(m1_tvalid),
    .m00_axis_tlast(m1_tlast), .m00_axis_tdata(m1_tdata),
    .m00_axis_tstrb(m1_tstrb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Output words {tlast, Q, I} in transfer order, plus the edge index of
  // each dut transfer. Handshakes are stable between negedge and posedge.
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  int          q0_cyc[$];

  always @(negedge clk) begin
    if (rst_n && m0_tvalid && m_tready) begin
      q0.push_back({m0_tlast, m0_tdata});
      q0_cyc.push_back(cyc + 1);
    end
    if (rst_n && m1_tvalid && m_tready) q1.push_back({m1_tlast, m1_tdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] word(input logic l, input int i, input int q);
    return {l, 16'(q), 16'(i)};
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Independent reference: exact phasor for a 10-bit address.
  function automatic logic [32:0] ref_word(input int addr);
    real a;
    a = 2.0 * PI * addr / 1024.0;
    return word(1'b0, rnd(32767.0 * $cos(a)), rnd(32767.0 * $sin(a)));
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    q0_cyc.delete();
  endtask

  // Present one sample until accepted; returns the edge index of acceptance.
  task automatic send(input logic [15:0] d, input logic l, output int acc_cyc);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = {16'h5A5A, d};
    s_tlast  = l;
    n = 0;
    @(negedge clk);
    while (!s0_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", s0_tready, 1'b1);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_q(input bit which, input int n);
    int t;
    t = 0;
    while (((which ? q1.size() : q0.size()) < n) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(which ? "wait_out_dut1" : "wait_out_dut",
          ((which ? q1.size() : q0.size()) >= n), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          first_acc;
    int          bad;
    int          idx;
    logic        accepted;
    logic [31:0] held_d;
    logic        held_l;

    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tstrb  = 4'h0;
    m_tready = 1'b1;
    held_d   = '0;
    held_l   = 1'b0;

    // ---- reset state -------------------------------------------------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m0_tvalid, 1'b0);
    check("rst_tdata", m0_tdata, 32'h0);
    check("rst_tlast", m0_tlast, 1'b0);
    check("rst_tstrb", m0_tstrb, 4'h0);
    check("rst_s_tready", s0_tready, 1'b1);
    rst_n = 1'b1;

    // ---- zero samples: constant phasor, latency 3 -------------------------
    first_acc = 0;
    for (int i = 0; i < 10; i++) begin
      send(16'd0, 1'b0, acc);
      if (i == 0) first_acc = acc;
    end
    wait_q(1'b0, 10);
    check("latency", q0_cyc[0] - first_acc, 3);
    for (int n = 0; n < 10; n++) check("zero_in_out", q0[n], word(1'b0, 32767, 0));
    repeat (3) @(posedge clk);
    #1;
    check("drained_tvalid", m0_tvalid, 1'b0);
    check("drained_tstrb", m0_tstrb, 4'h0);

    // ---- sweep: 16384 per sample -> addr steps by 1 -------------------------
    do_reset();
    for (int i = 0; i < 769; i++) send(16'd16384, 1'b0, acc);
    wait_q(1'b0, 769);
    check("sweep_0", q0[0], word(1'b0, 32767, 0));
    check("sweep_64", q0[64], word(1'b0, 30273, 12539));
    check("sweep_128", q0[128], word(1'b0, 23170, 23170));
    check("sweep_256", q0[256], word(1'b0, 0, 32767));
    check("sweep_512", q0[512], word(1'b0, -32767, 0));
    check("sweep_768", q0[768], word(1'b0, 0, -32767));
    bad = 0;
    for (int n = 0; n < 769; n++) if (q0[n] !== ref_word(n)) bad++;
    check("sweep_mismatch_count", bad, 0);

    // ---- accumulator wrap: CENTER_INC = 2^23 -------------------------------
    do_reset();
    for (int i = 0; i < 6; i++) send(16'd0, 1'b0, acc);
    wait_q(1'b1, 6);
    for (int n = 0; n < 6; n++)
      check("wrap_alternate", q1[n], (n % 2 == 0) ? word(1'b0, 32767, 0) : word(1'b0, -32767, 0));

    // ---- output stall for 5 cycles mid-stream ------------------------------
    do_reset();
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      m_tready = !(c >= 8 && c < 13);
      s_tvalid = (idx < 16);
      s_tdata  = 32'h0000_4000;
      s_tlast  = 1'b0;
      @(negedge clk);
      if (c == 8) begin
        held_d = m0_tdata;
        held_l = m0_tlast;
      end
      if (c >= 8 && c < 13) begin
        check("stall_s_tready", s0_tready, 1'b0);
        check("stall_tvalid", m0_tvalid, 1'b1);
        check("stall_tstrb", m0_tstrb, 4'hF);
      end
      if (c >= 9 && c < 13) begin
        check("stall_tdata_hold", m0_tdata, held_d);
        check("stall_tlast_hold", m0_tlast, held_l);
      end
      accepted = s_tvalid && s0_tready;
      @(posedge clk); #1;
      if (accepted) idx++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    wait_q(1'b0, 16);
    repeat (5) @(posedge clk);
    #1;
    check("stall_word_count", q0.size(), 16);
    for (int n = 0; n < 16; n++) check("stall_sequence", q0[n], ref_word(n));

    // ---- tlast alignment ---------------------------------------------------
    do_reset();
    for (int i = 0; i < 10; i++) send(16'd16384, (i == 7), acc);
    wait_q(1'b0, 10);
    for (int n = 0; n < 10; n++) check("tlast_position", q0[n][32], (n == 7));

    // ---- reset mid-stream --------------------------------------------------
    for (int i = 0; i < 4; i++) send(16'd16384, 1'b0, acc);
    check("pre_reset_tvalid", m0_tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_tvalid", m0_tvalid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q0.delete();
    q0_cyc.delete();
    send(16'd16384, 1'b0, acc);
    wait_q(1'b0, 1);
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_count", q0.size(), 1);
    check("post_reset_word", q0[0], word(1'b0, 32767, 0));

`ifdef FM_MOD_DITHER_EN
    // ---- dither: LFSR sequence and address held at 0 -----------------------
    begin
      logic [15:0] lfsr_m;
      do_reset();
      lfsr_m = 16'hACE1;
      check("lfsr_seed", dut.r_lfsr, lfsr_m);
      for (int i = 0; i < 8; i++) begin
        send(16'd0, 1'b0, acc);
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        check("lfsr_step", dut.r_lfsr, lfsr_m);
      end
      wait_q(1'b0, 8);
      for (int n = 0; n < 8; n++) check("dither_out", q0[n], word(1'b0, 32767, 0));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
